mod_i2c_arbiter: RTL and testbench

//  Shares the single APB-configured I2C master core between NREQ on-chip requesters.

---
 rtl/mod_i2c_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mod_i2c_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master core between NREQ requesters,
// with a watchdog that aborts a transfer the master never finishes.
module mod_i2c_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 20000,
    parameter int unsigned TW      = 15
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_speed,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rdata,
    output logic              nack,
    output logic              err,
    output logic              m_start,
    output logic [6:0]        m_addr,
    output logic              m_rw,
    output logic [7:0]        m_data,
    output logic              m_speed,
    output logic              m_abort,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic [7:0]        m_rdata,
    input  logic              m_nack
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StAbort} state_e;

    state_e          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic [TW-1:0]   r_wdt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic [7:0]      r_rdata;
    logic            r_nack;
    logic            r_err;
    logic            r_start;
    logic [6:0]      r_addr;
    logic            r_rw;
    logic [7:0]      r_data;
    logic            r_speed;
    logic            r_abort;

    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [PW:0]     w_idx;
    logic [NREQ-1:0] w_onehot;
    logic [6:0]      w_addr;
    logic            w_rw;
    logic [7:0]      w_data;
    logic            w_speed;
    logic [PW-1:0]   w_ptr_nxt;
    logic            w_wdt_exp;

    // First requesting index at or above r_ptr, wrapping past NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + (PW + 1)'(i);
            if (w_idx >= (PW + 1)'(NREQ)) begin
                w_idx = w_idx - (PW + 1)'(NREQ);
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        w_addr   = '0;
        w_rw     = 1'b0;
        w_data   = '0;
        w_speed  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PW'(i)) begin
                w_onehot[i] = 1'b1;
                w_addr      = req_addr[7*i +: 7];
                w_rw        = req_rw[i];
                w_data      = req_data[8*i +: 8];
                w_speed     = req_speed[i];
            end
        end
    end

    assign w_ptr_nxt = (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
    assign w_wdt_exp = (r_wdt == TW'(TIMEOUT - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_win   <= '0;
            r_wdt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_nack  <= 1'b0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_data  <= '0;
            r_speed <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_wdt <= '0;
                    if (w_found) begin
                        r_gnt   <= w_onehot;
                        r_win   <= w_win;
                        r_addr  <= w_addr;
                        r_rw    <= w_rw;
                        r_data  <= w_data;
                        r_speed <= w_speed;
                        r_start <= 1'b1;
                        r_state <= StIssue;
                    end
                end
                StIssue, StWait: begin
                    r_wdt <= r_wdt + 1'b1;
                    // Completion beats both the busy handshake and the watchdog.
                    if (m_done) begin
                        r_start <= 1'b0;
                        r_done  <= r_gnt;
                        r_rdata <= m_rdata;
                        r_nack  <= m_nack;
                        r_err   <= 1'b0;
                        r_state <= StResp;
                    end else if (w_wdt_exp) begin
                        r_start <= 1'b0;
                        r_abort <= 1'b1;
                        r_done  <= r_gnt;
                        r_rdata <= '0;
                        r_nack  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= StAbort;
                    end else if (r_state == StIssue && m_busy) begin
                        r_start <= 1'b0;
                        r_state <= StWait;
                    end
                end
                StResp, StAbort: begin
                    r_done  <= '0;
                    r_abort <= 1'b0;
                    r_gnt   <= '0;
                    r_ptr   <= w_ptr_nxt;
                    r_wdt   <= '0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign rdata   = r_rdata;
    assign nack    = r_nack;
    assign err     = r_err;
    assign m_start = r_start;
    assign m_addr  = r_addr;
    assign m_rw    = r_rw;
    assign m_data  = r_data;
    assign m_speed = r_speed;
    assign m_abort = r_abort;

endmodule

// File: tb/tb_mod_i2c_arbiter.sv
// Directed bench for mod_i2c_arbiter: stimulus pushes expected done responses,
// a negedge monitor pops and compares whenever done pulses.
module tb_mod_i2c_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 50;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_rw;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_speed;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        rdata;
    logic              nack;
    logic              err;
    logic              m_start;
    logic [6:0]        m_addr;
    logic              m_rw;
    logic [7:0]        m_data;
    logic              m_speed;
    logic              m_abort;
    logic              m_busy;
    logic              m_done;
    logic [7:0]        m_rdata;
    logic              m_nack;

    int n_checks = 0;
    int n_errors = 0;
    int last_lat = 0;

    // {done, rdata, nack, err, m_abort}
    logic [14:0] sb_q[$];

    always #5 PCLK = ~PCLK;

    mod_i2c_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .TW      (15)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_data  (req_data),
        .req_speed (req_speed),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .nack      (nack),
        .err       (err),
        .m_start   (m_start),
        .m_addr    (m_addr),
        .m_rw      (m_rw),
        .m_data    (m_data),
        .m_speed   (m_speed),
        .m_abort   (m_abort),
        .m_busy    (m_busy),
        .m_done    (m_done),
        .m_rdata   (m_rdata),
        .m_nack    (m_nack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge PCLK);
            if (done !== '0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", {17'd0, done, rdata, nack, err, m_abort}, 32'd0);
                end else begin
                    chk("response", {17'd0, done, rdata, nack, err, m_abort},
                        {17'd0, sb_q.pop_front()});
                end
            end
        end
    end

    // dly: >0 cycles of WAIT before m_done, -1 m_done during ISSUE, -2 never done.
    task automatic xfer(input logic [3:0] rq, input logic [3:0] eg, input int dly,
                        input logic [7:0] mrd, input logic mnk,
                        input logic [3:0] rq_after, input bit scramble);
        int idx;
        int k;
        logic [16:0] ef;
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (eg[i]) idx = i;
        @(posedge PCLK); #1;
        req = rq;
        ef = {req_addr[7*idx +: 7], req_rw[idx], req_data[8*idx +: 8], req_speed[idx]};
        if (dly == -2) sb_q.push_back({eg, 8'h00, 1'b0, 1'b1, 1'b1});
        else           sb_q.push_back({eg, mrd, mnk, 1'b0, 1'b0});
        k = 0;
        do begin
            @(posedge PCLK); #1;
            k++;
        end while (gnt == '0 && k < 8);
        last_lat = k;
        chk("grant", {28'd0, gnt}, {28'd0, eg});
        chk("cmd_fields", {15'd0, m_addr, m_rw, m_data, m_speed}, {15'd0, ef});
        chk("m_start_issue", {31'd0, m_start}, 32'd1);
        if (scramble) begin
            req_addr = ~req_addr;
            req_data = ~req_data;
            req      = req & ~eg;
        end
        if (dly == -1) begin
            m_rdata = mrd;
            m_nack  = mnk;
            m_done  = 1'b1;
            @(posedge PCLK); #1;
            m_done  = 1'b0;
        end else begin
            m_busy = 1'b1;
            @(posedge PCLK); #1;
            chk("m_start_drop", {31'd0, m_start}, 32'd0);
            if (dly == -2) begin
                k = 1;
                while (!m_abort && k < 200) begin
                    @(posedge PCLK); #1;
                    k++;
                end
                chk("abort_cycles", k, TIMEOUT);
            end else begin
                repeat (dly - 1) @(posedge PCLK);
                #1;
                m_rdata = mrd;
                m_nack  = mnk;
                m_done  = 1'b1;
                @(posedge PCLK); #1;
                m_done  = 1'b0;
            end
            m_busy = 1'b0;
        end
        k = 0;
        while (done == '0 && k < 4) begin
            @(posedge PCLK); #1;
            k++;
        end
        chk("done_vec", {28'd0, done}, {28'd0, eg});
        chk("cmd_stable", {15'd0, m_addr, m_rw, m_data, m_speed}, {15'd0, ef});
        req = rq_after;
        @(posedge PCLK); #1;
        chk("idle_gap", {28'd0, gnt}, 32'd0);
        chk("done_1cycle", {28'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k;
        PRESET    = 1'b1;
        req       = '0;
        req_addr  = {7'h77, 7'h1A, 7'h11, 7'h42};
        req_data  = {8'h9E, 8'h00, 8'hC3, 8'hF5};
        req_rw    = 4'b0100;
        req_speed = 4'b1010;
        m_busy    = 1'b0;
        m_done    = 1'b0;
        m_rdata   = '0;
        m_nack    = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        chk("reset_outputs", {gnt, done, rdata, nack, err, m_start, m_addr, m_abort}, 32'd0);

        // Single write from requester 0.
        xfer(4'b0001, 4'b0001, 40, 8'h00, 1'b0, 4'b0000, 1'b0);
        chk("gnt_latency", last_lat, 1);
        // Read from requester 2; it drops req and rewrites its slice mid-transfer.
        xfer(4'b0100, 4'b0100, 10, 8'h3D, 1'b0, 4'b0000, 1'b1);
        // NACKed write from requester 3 leaves ptr at 0.
        xfer(4'b1000, 4'b1000, 5, 8'h00, 1'b1, 4'b0000, 1'b0);

        // Round robin with all requests held.
        xfer(4'b1111, 4'b0001, 3, 8'h11, 1'b0, 4'b1111, 1'b0);
        xfer(4'b1111, 4'b0010, 3, 8'h22, 1'b0, 4'b1111, 1'b0);
        xfer(4'b1111, 4'b0100, 3, 8'h33, 1'b0, 4'b1111, 1'b0);
        xfer(4'b1111, 4'b1000, 3, 8'h44, 1'b0, 4'b1111, 1'b0);
        xfer(4'b1111, 4'b0001, 3, 8'h55, 1'b0, 4'b0000, 1'b0);

        // Watchdog abort on requester 1, then requester 2 still gets served.
        xfer(4'b0110, 4'b0010, -2, 8'h00, 1'b0, 4'b0100, 1'b0);
        xfer(4'b0100, 4'b0100, 3, 8'h66, 1'b0, 4'b0000, 1'b0);

        // m_done coincides with the last watchdog cycle.
        xfer(4'b1000, 4'b1000, 49, 8'hA5, 1'b0, 4'b0000, 1'b0);
        // m_done while still in ISSUE.
        xfer(4'b0010, 4'b0010, -1, 8'h5C, 1'b1, 4'b0000, 1'b0);

        // Reset in the middle of WAIT, ptr currently 2.
        @(posedge PCLK); #1;
        req = 4'b0100;
        k = 0;
        do begin
            @(posedge PCLK); #1;
            k++;
        end while (gnt == '0 && k < 8);
        chk("pre_reset_grant", {28'd0, gnt}, 32'd4);
        m_busy = 1'b1;
        repeat (10) @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        m_busy = 1'b0;
        req    = '0;
        chk("reset_mid", {gnt, done, rdata, nack, err, m_start, m_addr, m_abort}, 32'd0);
        xfer(4'b1010, 4'b0010, 5, 8'h77, 1'b0, 4'b0000, 1'b0);

        repeat (5) @(posedge PCLK);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
